tile_sched: RTL and testbench
=============================

TILE_SCHED -- requirements
Module: tile_sched

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 8 and set the width of all address and stride ports.
REQ-002 Parameter NUM_BUF SHALL default to 2 and set the number of downstream tile buffers, which is also the credit count.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 clr  in  1  synchronous clear.
REQ-006 layer_start  in  1  single-cycle request to begin a layer.
REQ-007 num_rows  in  6  number of real (non-pad) rows in the layer.
REQ-008 pad_top, pad_bot  in  1 each  add one all-pad row before or after the real rows.
REQ-009 row_len  in  6  elements per row, forwarded unchanged to the mover.
REQ-010 base_addr_rd, base_addr_wr  in  ADDR_WIDTH  layer start addresses.
REQ-011 row_stride_rd, row_stride_wr  in  ADDR_WIDTH  per-row address increments.
REQ-012 stride_chan  in  ADDR_WIDTH; chan_num  in  10  forwarded unchanged to the mover.
REQ-013 mv_done  in  1  mover row-complete pulse.
REQ-014 buf_release  in  1  consumer returns one buffer credit.
REQ-015 mv_start, mv_clr, mv_pad_all  out  1 each  mover controls.
REQ-016 mv_base_addr_rd, mv_base_addr_wr, mv_stride_chan  out  ADDR_WIDTH  mover configuration.
REQ-017 mv_row_len  out  6; mv_chan_num  out  10  mover configuration.
REQ-018 busy, layer_done  out  1 each; row_idx  out  7  index of the current row.

Function
REQ-019 The FSM SHALL have the states IDLE, CHECK, START, WAIT, ADV and DONE.
REQ-020 In IDLE, layer_start SHALL latch all config inputs; the FSM SHALL go to CHECK, or to DONE if total = num_rows + pad_top + pad_bot = 0.
REQ-021 layer_start SHALL be ignored in every state other than IDLE.
REQ-022 CHECK SHALL go to START only when credits > 0, and SHALL otherwise stay in CHECK.
REQ-023 START SHALL assert mv_start for exactly one cycle, decrement credits, and go to WAIT.
REQ-024 WAIT SHALL go to ADV on mv_done; mv_done SHALL be ignored in every state other than WAIT.
REQ-025 ADV SHALL increment row_idx; it SHALL go to DONE if row_idx was total-1, and otherwise to CHECK.
REQ-026 DONE SHALL pulse layer_done for one cycle and then return to IDLE.
REQ-027 A row SHALL be a pad row if it is row 0 with pad_top=1, or row total-1 with pad_bot=1; mv_pad_all SHALL be 1 for pad rows and 0 otherwise.
REQ-028 The write address SHALL advance by row_stride_wr after every row, including pad rows.
REQ-029 The read address SHALL advance by row_stride_rd only after real rows.
REQ-030 All address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-031 mv_base_addr_* and mv_pad_all SHALL be registered and stable from START through WAIT.
REQ-032 The credit counter SHALL reset to NUM_BUF, decrement on mv_start, and increment on buf_release.
REQ-033 mv_start and buf_release in the same cycle SHALL leave the credit count unchanged.
REQ-034 buf_release at NUM_BUF credits SHALL be ignored (saturate).
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 mv_row_len, mv_stride_chan and mv_chan_num SHALL equal the latched config values.
REQ-037 clr SHALL return the FSM to IDLE, reset credits and all outputs, and drive mv_clr=clr combinationally.
REQ-038 clr SHALL take priority over every other input.

Reset
REQ-039 While rst_n=0, all outputs, row_idx and addresses SHALL be 0, credits SHALL be NUM_BUF, and the FSM SHALL be in IDLE.
REQ-040 Reset asserted mid-layer SHALL abort the layer immediately and SHALL not produce layer_done.

Verification
REQ-041 Basic layer: num_rows=3, no pads, base_rd=16, row_stride_rd=4, base_wr=32, row_stride_wr=8, release after each row -> three mv_start pulses with rd 16/20/24 and wr 32/40/48, then one layer_done.
REQ-042 Padded layer: num_rows=2, pad_top=1, pad_bot=1 -> four rows; mv_pad_all = 1,0,0,1; rd 16,16,20 on the real rows only; wr 32,40,48,56.
REQ-043 Credit stall: NUM_BUF=2, no buf_release -> exactly two mv_start pulses, the FSM holds in CHECK with busy=1; one buf_release -> the third start follows within 2 cycles.
REQ-044 Corner cases: total=0 -> layer_done two cycles after layer_start with no mv_start; buf_release together with mv_start -> credits unchanged; buf_release at full credits -> count stays 2.
REQ-045 Abort: clr asserted during WAIT -> mv_clr=1 that cycle, IDLE next cycle, credits=2, no layer_done; rst_n pulsed mid-layer -> same outcome asynchronously.
REQ-046 Wrap: base_rd=252, row_stride_rd=4, num_rows=2 -> rd 252 then 0.

Source files
------------

// File: rtl/tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tile_sched
// Brief    : Row-by-row tile scheduler. Issues one mover start per row,
//            generates per-row read/write base addresses with optional pad
//            rows at the top and bottom of a layer, and throttles row starts
//            against a credit pool of downstream tile buffers.
// Revision : 1.0 - initial release
// ============================================================================
module tile_sched #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BUF    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  layer_start,
    input  logic [5:0]            num_rows,
    input  logic                  pad_top,
    input  logic                  pad_bot,
    input  logic [5:0]            row_len,
    input  logic [ADDR_WIDTH-1:0] base_addr_rd,
    input  logic [ADDR_WIDTH-1:0] base_addr_wr,
    input  logic [ADDR_WIDTH-1:0] row_stride_rd,
    input  logic [ADDR_WIDTH-1:0] row_stride_wr,
    input  logic [ADDR_WIDTH-1:0] stride_chan,
    input  logic [9:0]            chan_num,
    input  logic                  mv_done,
    input  logic                  buf_release,
    output logic                  mv_start,
    output logic                  mv_clr,
    output logic                  mv_pad_all,
    output logic [ADDR_WIDTH-1:0] mv_base_addr_rd,
    output logic [ADDR_WIDTH-1:0] mv_base_addr_wr,
    output logic [ADDR_WIDTH-1:0] mv_stride_chan,
    output logic [5:0]            mv_row_len,
    output logic [9:0]            mv_chan_num,
    output logic                  busy,
    output logic                  layer_done,
    output logic [6:0]            row_idx
);

    localparam int CW = $clog2(NUM_BUF + 1);
    localparam logic [CW-1:0] C_CREDIT_FULL = CW'(NUM_BUF);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_ADV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         credit_q;
    logic [CW-1:0]         credit_d;
    logic [6:0]            row_idx_q;
    logic [6:0]            total_q;
    logic [6:0]            total_d;
    logic                  pad_top_q;
    logic                  pad_bot_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] stride_rd_q;
    logic [ADDR_WIDTH-1:0] stride_wr_q;
    logic [ADDR_WIDTH-1:0] stride_chan_q;
    logic [5:0]            row_len_q;
    logic [9:0]            chan_num_q;
    logic                  mv_start_q;
    logic                  mv_pad_all_q;
    logic [ADDR_WIDTH-1:0] mv_base_addr_rd_q;
    logic [ADDR_WIDTH-1:0] mv_base_addr_wr_q;
    logic                  layer_done_q;
    logic                  pad_row_w;
    logic                  last_row_w;
    logic                  rel_ok_w;

    // Row count including the optional pad rows; at most 63+1+1 fits 7 bits.
    assign total_d    = 7'(num_rows) + 7'(pad_top) + 7'(pad_bot);
    assign last_row_w = (row_idx_q == 7'(total_q - 7'd1));
    assign pad_row_w  = ((row_idx_q == 7'd0) && pad_top_q) || (last_row_w && pad_bot_q);

    // A release is accepted below full credits, or at full credits when a
    // start consumes one in the same cycle (net count unchanged).
    assign rel_ok_w = buf_release && ((credit_q < C_CREDIT_FULL) || mv_start_q);

    // Credit next-state: start consumes, release returns, both together cancel.
    always_comb begin
        credit_d = credit_q;
        case ({mv_start_q, rel_ok_w})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    // Credit pool register; clear refills it just like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= C_CREDIT_FULL;
        end else if (clr) begin
            credit_q <= C_CREDIT_FULL;
        end else begin
            credit_q <= credit_d;
        end
    end

    // Scheduler FSM with config latch, address walkers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            row_idx_q         <= '0;
            total_q           <= '0;
            pad_top_q         <= 1'b0;
            pad_bot_q         <= 1'b0;
            rd_addr_q         <= '0;
            wr_addr_q         <= '0;
            stride_rd_q       <= '0;
            stride_wr_q       <= '0;
            stride_chan_q     <= '0;
            row_len_q         <= '0;
            chan_num_q        <= '0;
            mv_start_q        <= 1'b0;
            mv_pad_all_q      <= 1'b0;
            mv_base_addr_rd_q <= '0;
            mv_base_addr_wr_q <= '0;
            layer_done_q      <= 1'b0;
        end else if (clr) begin
            state_q           <= S_IDLE;
            row_idx_q         <= '0;
            total_q           <= '0;
            pad_top_q         <= 1'b0;
            pad_bot_q         <= 1'b0;
            rd_addr_q         <= '0;
            wr_addr_q         <= '0;
            stride_rd_q       <= '0;
            stride_wr_q       <= '0;
            stride_chan_q     <= '0;
            row_len_q         <= '0;
            chan_num_q        <= '0;
            mv_start_q        <= 1'b0;
            mv_pad_all_q      <= 1'b0;
            mv_base_addr_rd_q <= '0;
            mv_base_addr_wr_q <= '0;
            layer_done_q      <= 1'b0;
        end else begin
            mv_start_q   <= 1'b0;
            layer_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (layer_start) begin
                        total_q       <= total_d;
                        pad_top_q     <= pad_top;
                        pad_bot_q     <= pad_bot;
                        rd_addr_q     <= base_addr_rd;
                        wr_addr_q     <= base_addr_wr;
                        stride_rd_q   <= row_stride_rd;
                        stride_wr_q   <= row_stride_wr;
                        stride_chan_q <= stride_chan;
                        row_len_q     <= row_len;
                        chan_num_q    <= chan_num;
                        row_idx_q     <= '0;
                        state_q       <= (total_d == 7'd0) ? S_DONE : S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Addresses and pad flag are captured here so they stay
                    // constant for the whole START/WAIT window of the row.
                    if (credit_q != '0) begin
                        mv_start_q        <= 1'b1;
                        mv_base_addr_rd_q <= rd_addr_q;
                        mv_base_addr_wr_q <= wr_addr_q;
                        mv_pad_all_q      <= pad_row_w;
                        state_q           <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mv_done) begin
                        state_q <= S_ADV;
                    end
                end
                S_ADV: begin
                    // Write side always advances; read side skips pad rows
                    // because they consume no source data.
                    row_idx_q <= row_idx_q + 7'd1;
                    wr_addr_q <= wr_addr_q + stride_wr_q;
                    if (!pad_row_w) begin
                        rd_addr_q <= rd_addr_q + stride_rd_q;
                    end
                    state_q <= last_row_w ? S_DONE : S_CHECK;
                end
                S_DONE: begin
                    layer_done_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mv_start        = mv_start_q;
    assign mv_clr          = clr;
    assign mv_pad_all      = mv_pad_all_q;
    assign mv_base_addr_rd = mv_base_addr_rd_q;
    assign mv_base_addr_wr = mv_base_addr_wr_q;
    assign mv_stride_chan  = stride_chan_q;
    assign mv_row_len      = row_len_q;
    assign mv_chan_num     = chan_num_q;
    assign busy            = (state_q != S_IDLE);
    assign layer_done      = layer_done_q;
    assign row_idx         = row_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_sched
// Brief    : Scoreboard bench for tile_sched. Directed layers push the
//            hand-computed per-row mover configuration into a queue; a
//            monitor pops and compares on every mv_start and tracks
//            expected layer_done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_sched;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          layer_start;
    logic [5:0]    num_rows;
    logic          pad_top;
    logic          pad_bot;
    logic [5:0]    row_len;
    logic [AW-1:0] base_addr_rd;
    logic [AW-1:0] base_addr_wr;
    logic [AW-1:0] row_stride_rd;
    logic [AW-1:0] row_stride_wr;
    logic [AW-1:0] stride_chan;
    logic [9:0]    chan_num;
    logic          mv_done;
    logic          buf_release;
    logic          mv_start;
    logic          mv_clr;
    logic          mv_pad_all;
    logic [AW-1:0] mv_base_addr_rd;
    logic [AW-1:0] mv_base_addr_wr;
    logic [AW-1:0] mv_stride_chan;
    logic [5:0]    mv_row_len;
    logic [9:0]    mv_chan_num;
    logic          busy;
    logic          layer_done;
    logic [6:0]    row_idx;

    tile_sched #(.ADDR_WIDTH(AW), .NUM_BUF(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr             (clr),
        .layer_start     (layer_start),
        .num_rows        (num_rows),
        .pad_top         (pad_top),
        .pad_bot         (pad_bot),
        .row_len         (row_len),
        .base_addr_rd    (base_addr_rd),
        .base_addr_wr    (base_addr_wr),
        .row_stride_rd   (row_stride_rd),
        .row_stride_wr   (row_stride_wr),
        .stride_chan     (stride_chan),
        .chan_num        (chan_num),
        .mv_done         (mv_done),
        .buf_release     (buf_release),
        .mv_start        (mv_start),
        .mv_clr          (mv_clr),
        .mv_pad_all      (mv_pad_all),
        .mv_base_addr_rd (mv_base_addr_rd),
        .mv_base_addr_wr (mv_base_addr_wr),
        .mv_stride_chan  (mv_stride_chan),
        .mv_row_len      (mv_row_len),
        .mv_chan_num     (mv_chan_num),
        .busy            (busy),
        .layer_done      (layer_done),
        .row_idx         (row_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-layer forwarding config; inputs are scrambled after each start
    // so the mover outputs must come from the latched copy.
    localparam logic [5:0]    C_RL = 6'd12;
    localparam logic [9:0]    C_CN = 10'd300;
    localparam logic [AW-1:0] C_SC = 8'd7;

    typedef struct {
        logic [AW-1:0] rd;
        logic [AW-1:0] wr;
        logic          pad;
        logic [6:0]    row;
    } exp_t;

    exp_t sbq[$];
    int   exp_done = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] rd, input logic [AW-1:0] wr,
                        input logic pad, input logic [6:0] row);
        exp_t e;
        e.rd = rd; e.wr = wr; e.pad = pad; e.row = row;
        sbq.push_back(e);
    endtask

    // Monitor: every mover start is compared against the next queued row.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mv_start) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_mv_start", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("row_idx", 32'(row_idx), 32'(e.row));
                    chk("mv_base_addr_rd", 32'(mv_base_addr_rd), 32'(e.rd));
                    chk("mv_base_addr_wr", 32'(mv_base_addr_wr), 32'(e.wr));
                    chk("mv_pad_all", 32'(mv_pad_all), 32'(e.pad));
                    chk("mv_row_len", 32'(mv_row_len), 32'(C_RL));
                    chk("mv_chan_num", 32'(mv_chan_num), 32'(C_CN));
                    chk("mv_stride_chan", 32'(mv_stride_chan), 32'(C_SC));
                end
            end
            if (layer_done) begin
                if (exp_done == 0) chk("unexpected_layer_done", 1, 0);
                else begin
                    chk("layer_done_expected", 1, 1);
                    exp_done--;
                end
            end
        end
    end

    task automatic set_cfg(input logic [5:0] rows, input logic pt, input logic pb,
                           input logic [AW-1:0] brd, input logic [AW-1:0] srd,
                           input logic [AW-1:0] bwr, input logic [AW-1:0] swr);
        num_rows = rows; pad_top = pt; pad_bot = pb;
        base_addr_rd = brd; row_stride_rd = srd;
        base_addr_wr = bwr; row_stride_wr = swr;
        row_len = C_RL; chan_num = C_CN; stride_chan = C_SC;
    endtask

    task automatic start_layer();
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        num_rows = 6'd63; pad_top = 1'b1; pad_bot = 1'b1;
        base_addr_rd = 8'hAA; base_addr_wr = 8'h55;
        row_stride_rd = 8'h11; row_stride_wr = 8'h22;
        row_len = 6'd1; chan_num = 10'd1; stride_chan = 8'd1;
    endtask

    // Mover/consumer model: completes each row two cycles after its start,
    // optionally returning a buffer credit with the completion.
    task automatic drive(input bit rel, input int budget, input int t0,
                         output int starts, output bit done);
        int t;
        t = t0; starts = 0; done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            mv_done = 1'b0; buf_release = 1'b0;
            if (layer_done) done = 1'b1;
            else begin
                if (mv_start) begin
                    starts++; t = 2;
                end else if (t > 0) begin
                    t--;
                    if (t == 0) begin
                        mv_done = 1'b1; buf_release = rel; t = -1;
                    end
                end
                @(negedge clk);
            end
        end
        mv_done = 1'b0; buf_release = 1'b0;
    endtask

    task automatic wait_start(input string name, input int budget);
        int c;
        c = 0;
        while (!mv_start && c < budget) begin
            @(negedge clk); c++;
        end
        if (!mv_start) chk(name, 0, 1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    // Expect exactly two starts of a three-row layer with no credits returned.
    task automatic two_credit_probe(input string name);
        int s; bit d;
        set_cfg(6'd3, 1'b0, 1'b0, 8'd16, 8'd4, 8'd32, 8'd8);
        push(8'd16, 8'd32, 1'b0, 7'd0);
        push(8'd20, 8'd40, 1'b0, 7'd1);
        start_layer();
        drive(1'b0, 40, -1, s, d);
        chk({name, "_starts"}, 32'(s), 2);
        chk({name, "_busy"}, 32'(busy), 1);
        pulse_clr();
    endtask

    initial begin
        int  s;
        bit  d;
        bit  found;
        int  k;

        rst_n = 1'b0; clr = 1'b0; layer_start = 1'b0;
        mv_done = 1'b0; buf_release = 1'b0;
        set_cfg(6'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mv_start", 32'(mv_start), 0);
        chk("rst_layer_done", 32'(layer_done), 0);
        chk("rst_row_idx", 32'(row_idx), 0);
        chk("rst_addr_rd", 32'(mv_base_addr_rd), 0);
        chk("rst_addr_wr", 32'(mv_base_addr_wr), 0);
        chk("rst_pad_all", 32'(mv_pad_all), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-row layer
        set_cfg(6'd3, 1'b0, 1'b0, 8'd16, 8'd4, 8'd32, 8'd8);
        push(8'd16, 8'd32, 1'b0, 7'd0);
        push(8'd20, 8'd40, 1'b0, 7'd1);
        push(8'd24, 8'd48, 1'b0, 7'd2);
        exp_done++;
        start_layer();
        chk("basic_busy", 32'(busy), 1);
        drive(1'b1, 200, -1, s, d);
        chk("basic_starts", 32'(s), 3);
        chk("basic_done", 32'(d), 1);
        chk("basic_idle_busy", 32'(busy), 0);
        @(negedge clk);

        // Padded layer: pad, real, real, pad
        set_cfg(6'd2, 1'b1, 1'b1, 8'd16, 8'd4, 8'd32, 8'd8);
        push(8'd16, 8'd32, 1'b1, 7'd0);
        push(8'd16, 8'd40, 1'b0, 7'd1);
        push(8'd20, 8'd48, 1'b0, 7'd2);
        push(8'd24, 8'd56, 1'b1, 7'd3);
        exp_done++;
        start_layer();
        drive(1'b1, 200, -1, s, d);
        chk("pad_starts", 32'(s), 4);
        chk("pad_done", 32'(d), 1);
        @(negedge clk);

        // Address wrap
        set_cfg(6'd2, 1'b0, 1'b0, 8'd252, 8'd4, 8'd250, 8'd8);
        push(8'd252, 8'd250, 1'b0, 7'd0);
        push(8'd0,   8'd2,   1'b0, 7'd1);
        exp_done++;
        start_layer();
        drive(1'b1, 200, -1, s, d);
        chk("wrap_starts", 32'(s), 2);
        chk("wrap_done", 32'(d), 1);
        @(negedge clk);

        // Empty layer: layer_done two cycles after layer_start
        set_cfg(6'd0, 1'b0, 1'b0, 8'd16, 8'd4, 8'd32, 8'd8);
        exp_done++;
        start_layer();
        chk("empty_done_early", 32'(layer_done), 0);
        chk("empty_busy", 32'(busy), 1);
        @(negedge clk);
        chk("empty_done", 32'(layer_done), 1);
        chk("empty_busy_after", 32'(busy), 0);
        @(negedge clk);
        chk("empty_done_single", 32'(layer_done), 0);

        // Release at full credits is ignored, then credit stall and resume
        buf_release = 1'b1;
        repeat (2) @(negedge clk);
        buf_release = 1'b0;
        set_cfg(6'd3, 1'b0, 1'b0, 8'd16, 8'd4, 8'd32, 8'd8);
        push(8'd16, 8'd32, 1'b0, 7'd0);
        push(8'd20, 8'd40, 1'b0, 7'd1);
        push(8'd24, 8'd48, 1'b0, 7'd2);
        exp_done++;
        start_layer();
        drive(1'b0, 30, -1, s, d);
        chk("stall_starts", 32'(s), 2);
        chk("stall_no_done", 32'(d), 0);
        chk("stall_busy", 32'(busy), 1);
        buf_release = 1'b1;
        found = 1'b0; k = 0;
        while (!found && k < 4) begin
            @(negedge clk);
            buf_release = 1'b0;
            k++;
            if (mv_start) found = 1'b1;
        end
        chk("resume_start_seen", 32'(found), 1);
        chk("resume_within_2", 32'(k <= 2), 1);
        drive(1'b1, 200, -1, s, d);
        chk("resume_starts", 32'(s), 1);
        chk("resume_done", 32'(d), 1);
        pulse_clr();

        // Release coincident with mv_start leaves the count at two
        set_cfg(6'd4, 1'b0, 1'b0, 8'd16, 8'd4, 8'd32, 8'd8);
        push(8'd16, 8'd32, 1'b0, 7'd0);
        push(8'd20, 8'd40, 1'b0, 7'd1);
        push(8'd24, 8'd48, 1'b0, 7'd2);
        start_layer();
        wait_start("coinc_first_start", 20);
        buf_release = 1'b1;
        @(negedge clk);
        buf_release = 1'b0;
        drive(1'b0, 40, 1, s, d);
        chk("coinc_more_starts", 32'(s), 2);
        chk("coinc_busy", 32'(busy), 1);
        pulse_clr();

        // clr during WAIT aborts the layer
        set_cfg(6'd3, 1'b0, 1'b0, 8'd16, 8'd4, 8'd32, 8'd8);
        push(8'd16, 8'd32, 1'b0, 7'd0);
        start_layer();
        wait_start("clr_first_start", 20);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_mv_clr", 32'(mv_clr), 1);
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 0);
        chk("clr_row_idx", 32'(row_idx), 0);
        chk("clr_addr_rd", 32'(mv_base_addr_rd), 0);
        chk("clr_row_len", 32'(mv_row_len), 0);
        chk("clr_mv_clr_low", 32'(mv_clr), 0);
        two_credit_probe("clr_credit");

        // Asynchronous reset mid-layer
        set_cfg(6'd3, 1'b0, 1'b0, 8'd16, 8'd4, 8'd32, 8'd8);
        push(8'd16, 8'd32, 1'b0, 7'd0);
        start_layer();
        wait_start("rst_first_start", 20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_row_idx", 32'(row_idx), 0);
        chk("arst_addr_wr", 32'(mv_base_addr_wr), 0);
        chk("arst_chan_num", 32'(mv_chan_num), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        two_credit_probe("arst_credit");

        repeat (3) @(negedge clk);
        chk("sb_queue_empty", 32'(sbq.size()), 0);
        chk("layer_done_all_seen", 32'(exp_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
